// File: rtl/uart_frame_ctrl.sv
// Frame parser behind the UART receiver: SYNC, CMD, LEN, payload, CSUM.
// Writes payload into the line buffer and presents good frames with valid/ack.
module uart_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 21700,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Frame_Ack,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Frame_Valid,
    output logic [7:0] o_Frame_Cmd,
    output logic [7:0] o_Frame_Len,
    output logic       o_Err,
    output logic [1:0] o_Err_Code
);

    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       wr_en_d;
    logic [7:0] wr_addr_d;
    logic [7:0] wr_data_d;
    logic       frame_valid_d;
    logic [7:0] frame_cmd_d;
    logic [7:0] frame_len_d;
    logic       err_d;
    logic [1:0] err_code_d;

    logic in_frame;
    logic timeout;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            csum_q        <= '0;
            cnt_q         <= '0;
            o_Wr_En       <= 1'b0;
            o_Wr_Addr     <= '0;
            o_Wr_Data     <= '0;
            o_Frame_Valid <= 1'b0;
            o_Frame_Cmd   <= '0;
            o_Frame_Len   <= '0;
            o_Err         <= 1'b0;
            o_Err_Code    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            csum_q        <= csum_d;
            cnt_q         <= cnt_d;
            o_Wr_En       <= wr_en_d;
            o_Wr_Addr     <= wr_addr_d;
            o_Wr_Data     <= wr_data_d;
            o_Frame_Valid <= frame_valid_d;
            o_Frame_Cmd   <= frame_cmd_d;
            o_Frame_Len   <= frame_len_d;
            o_Err         <= err_d;
            o_Err_Code    <= err_code_d;
        end
    end

    // Inter-byte watchdog only runs while a frame is being received; a DV wins over expiry.
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    assign timeout  = in_frame && !i_Rx_DV && (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        len_d         = len_q;
        idx_d         = idx_q;
        csum_d        = csum_q;
        cnt_d         = '0;
        wr_en_d       = 1'b0;
        wr_addr_d     = o_Wr_Addr;
        wr_data_d     = o_Wr_Data;
        frame_valid_d = o_Frame_Valid;
        frame_cmd_d   = o_Frame_Cmd;
        frame_len_d   = o_Frame_Len;
        err_d         = 1'b0;
        err_code_d    = o_Err_Code;

        if (in_frame && !i_Rx_DV) begin
            cnt_d = CNT_WIDTH'(cnt_q + CNT_WIDTH'(1));
        end

        if (timeout) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        csum_d  = '0;
                        idx_d   = '0;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (i_Rx_DV) begin
                        cmd_d   = i_Rx_Byte;
                        csum_d  = csum_q ^ i_Rx_Byte;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_Rx_DV) begin
                        len_d   = i_Rx_Byte;
                        csum_d  = csum_q ^ i_Rx_Byte;
                        state_d = (i_Rx_Byte == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = i_Rx_Byte;
                        csum_d    = csum_q ^ i_Rx_Byte;
                        idx_d     = 8'(idx_q + 8'd1);
                        if (idx_q == 8'(len_q - 8'd1)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == csum_q) begin
                            frame_valid_d = 1'b1;
                            frame_cmd_d   = cmd_q;
                            frame_len_d   = len_q;
                            state_d       = ST_HOLD;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CSUM;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // Ack takes priority over a colliding byte; a new SYNC here is a dropped frame.
                    if (i_Frame_Ack) begin
                        frame_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end else if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERRUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with a short inter-byte timeout.
module tb_uart_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       ack;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    int err_count = 0;
    int wr_base;
    int err_base;

    uart_frame_ctrl #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(100),
        .CNT_WIDTH   (16)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .i_Frame_Ack  (ack),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Frame_Valid(frame_valid),
        .o_Frame_Cmd  (frame_cmd),
        .o_Frame_Len  (frame_len),
        .o_Err        (err),
        .o_Err_Code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) wr_count++;
        if (err) err_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Byte is sampled on the posedge between the two negedges; outputs are then readable.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic send_payload(input string tag, input logic [7:0] b, input logic [7:0] addr);
        send_byte(b);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'(addr));
        check({tag, "_wr_data"}, 32'(wr_data), 32'(b));
        @(negedge clk);
        check({tag, "_wr_en_drop"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        ack     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        rst = 1'b0;

        // Good frame: A5 01 03 10 20 30 02
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        check("good_hdr_wr_en", 32'(wr_en), 32'd0);
        send_payload("good_p0", 8'h10, 8'd0);
        send_payload("good_p1", 8'h20, 8'd1);
        send_payload("good_p2", 8'h30, 8'd2);
        send_byte(8'h02);
        check("good_valid", 32'(frame_valid), 32'd1);
        check("good_cmd", 32'(frame_cmd), 32'h01);
        check("good_len", 32'(frame_len), 32'h03);
        check("good_err", 32'(err), 32'd0);
        repeat (5) @(negedge clk);
        check("good_hold_valid", 32'(frame_valid), 32'd1);
        check("good_hold_cmd", 32'(frame_cmd), 32'h01);
        do_ack();
        check("good_ack_valid", 32'(frame_valid), 32'd0);

        // Zero-length frame: A5 07 00 07
        wr_base = wr_count;
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h07);
        check("zero_valid", 32'(frame_valid), 32'd1);
        check("zero_cmd", 32'(frame_cmd), 32'h07);
        check("zero_len", 32'(frame_len), 32'h00);
        check("zero_writes", 32'(wr_count - wr_base), 32'd0);
        do_ack();

        // Bad checksum: A5 01 03 10 20 30 FF
        wr_base = wr_count;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        send_byte(8'hFF);
        check("bad_err", 32'(err), 32'd1);
        check("bad_code", 32'(err_code), 32'h1);
        check("bad_valid", 32'(frame_valid), 32'd0);
        check("bad_writes", 32'(wr_count - wr_base), 32'd3);
        @(negedge clk);
        check("bad_err_pulse", 32'(err), 32'd0);
        check("bad_code_hold", 32'(err_code), 32'h1);
        // Recovery: A5 02 01 55 56
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_payload("rec_p0", 8'h55, 8'd0);
        send_byte(8'h56);
        check("rec_valid", 32'(frame_valid), 32'd1);
        check("rec_cmd", 32'(frame_cmd), 32'h02);
        check("rec_len", 32'(frame_len), 32'h01);
        do_ack();

        // Timeout: A5 01 then silence, error 100 clocks after the 01 strobe
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (99) @(negedge clk);
        check("to_early", 32'(err), 32'd0);
        @(negedge clk);
        check("to_err", 32'(err), 32'd1);
        check("to_code", 32'(err_code), 32'h2);
        @(negedge clk);
        check("to_err_pulse", 32'(err), 32'd0);
        // Back in IDLE: an unsynced 07 00 07 must be ignored
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h07);
        check("to_idle_valid", 32'(frame_valid), 32'd0);
        check("to_idle_err", 32'(err), 32'd0);

        // DV on the expiry cycle wins: A5 01 ..98.. 00 01
        err_base = err_count;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (98) @(negedge clk);
        send_byte(8'h00);
        check("exp_dv_err", 32'(err), 32'd0);
        send_byte(8'h01);
        check("exp_dv_valid", 32'(frame_valid), 32'd1);
        check("exp_dv_cmd", 32'(frame_cmd), 32'h01);
        check("exp_dv_len", 32'(frame_len), 32'h00);
        check("exp_dv_errs", 32'(err_count - err_base), 32'd0);
        do_ack();

        // Overrun: A5 03 00 03 left unacked, then A5
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h03);
        check("ovr_valid0", 32'(frame_valid), 32'd1);
        send_byte(8'hA5);
        check("ovr_err", 32'(err), 32'd1);
        check("ovr_code", 32'(err_code), 32'h3);
        check("ovr_valid", 32'(frame_valid), 32'd1);
        check("ovr_cmd", 32'(frame_cmd), 32'h03);
        check("ovr_len", 32'(frame_len), 32'h00);
        @(negedge clk);
        check("ovr_err_pulse", 32'(err), 32'd0);
        send_byte(8'h04);
        check("ovr_other_err", 32'(err), 32'd0);
        check("ovr_other_valid", 32'(frame_valid), 32'd1);
        // Ack and SYNC in the same cycle: ack wins, no error
        @(negedge clk);
        ack     = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'hA5;
        @(negedge clk);
        ack     = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        check("collide_valid", 32'(frame_valid), 32'd0);
        check("collide_err", 32'(err), 32'd0);
        // New frame after ack: A5 09 01 AA A2
        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'h01);
        send_payload("post_p0", 8'hAA, 8'd0);
        send_byte(8'hA2);
        check("post_valid", 32'(frame_valid), 32'd1);
        check("post_cmd", 32'(frame_cmd), 32'h09);
        check("post_len", 32'(frame_len), 32'h01);
        do_ack();

        // Reset after the 2nd payload byte
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'd0);
        check("mid_rst_valid", 32'(frame_valid), 32'd0);
        check("mid_rst_cmd", 32'(frame_cmd), 32'd0);
        check("mid_rst_code", 32'(err_code), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        send_payload("post_rst_p0", 8'h10, 8'd0);
        send_payload("post_rst_p1", 8'h20, 8'd1);
        send_payload("post_rst_p2", 8'h30, 8'd2);
        send_byte(8'h02);
        check("post_rst_valid", 32'(frame_valid), 32'd1);
        check("post_rst_cmd", 32'(frame_cmd), 32'h01);
        check("post_rst_len", 32'(frame_len), 32'h03);
        do_ack();
        check("post_rst_ack", 32'(frame_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Packet controller behind the UART receiver in the image-capture path.
- Consumes the receiver's one-cycle byte-valid strobe and byte.
- Parses frames of the form SYNC, CMD, LEN, LEN payload bytes, CSUM.
- Writes payload bytes into an external pixel/line buffer, then presents the frame to the consumer with a valid/ack handshake. Reports checksum, timeout and overrun errors.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 21700: maximum idle clocks between bytes inside a frame (about 20 bit times at 1085 clocks/bit). Must be at least 2.
- CNT_WIDTH, 16: width of the timeout counter. Must satisfy 2**CNT_WIDTH > TIMEOUT_CLKS.

Ports:
- i_Clock  in  1  system clock; the only clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle strobe: received byte valid.
- i_Rx_Byte  in  8  received byte, valid while i_Rx_DV is high.
- i_Frame_Ack  in  1  consumer has taken the frame.
- o_Wr_En  out  1  buffer write strobe.
- o_Wr_Addr  out  8  buffer write address (payload index).
- o_Wr_Data  out  8  buffer write data.
- o_Frame_Valid  out  1  a complete frame with good checksum is available.
- o_Frame_Cmd  out  8  CMD of the presented frame.
- o_Frame_Len  out  8  LEN of the presented frame.
- o_Err  out  1  one-cycle error pulse.
- o_Err_Code  out  2  error cause: 01 checksum, 10 timeout, 11 overrun. Valid while o_Err is high; holds its last value otherwise.

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state, mid-frame included):
  - State goes to IDLE.
  - All outputs, the counters and the checksum accumulator go to 0.
  - Buffer contents already written are not rolled back.
- States: IDLE, CMD, LEN, PAYLOAD, CSUM, HOLD.
- IDLE:
  - On i_Rx_DV with byte == SYNC_BYTE: go to CMD; clear checksum accumulator, payload index and timeout counter.
  - Any other byte is ignored.
- CMD: on i_Rx_DV, latch the byte into the cmd register, accumulate it into the checksum (XOR), go to LEN.
- LEN:
  - On i_Rx_DV, latch the byte into the len register and accumulate it.
  - LEN == 0: go to CSUM. Otherwise go to PAYLOAD.
- PAYLOAD:
  - On i_Rx_DV, in the next cycle drive o_Wr_En=1, o_Wr_Addr = payload index, o_Wr_Data = byte. Latency is 1 clock from the strobe; o_Wr_En is high for exactly one cycle.
  - Accumulate the byte and increment the index.
  - After the byte with index LEN-1, go to CSUM.
  - Payload index is 8 bits and never wraps, because LEN <= 255.
- CSUM: on i_Rx_DV, compare the byte with the accumulator (XOR of CMD, LEN and all payload bytes).
  - Match: next cycle o_Frame_Valid=1, o_Frame_Cmd/o_Frame_Len loaded from the latched values; go to HOLD.
  - Mismatch: next cycle o_Err=1 with code 01; go to IDLE. o_Frame_Valid stays 0.
- HOLD:
  - o_Frame_Valid, o_Frame_Cmd and o_Frame_Len are held stable.
  - On i_Frame_Ack: o_Frame_Valid=0 next cycle; go to IDLE.
  - i_Rx_DV with SYNC_BYTE: o_Err pulse with code 11 (overrun); remain in HOLD. That frame is dropped.
  - Other bytes are ignored.
  - Ack and DV in the same cycle: ack is honoured, the byte is ignored, no error.
- Timeout, in states CMD/LEN/PAYLOAD/CSUM only:
  - The counter clears on every i_Rx_DV and increments on every other cycle.
  - When the counter equals TIMEOUT_CLKS-1 with no DV that cycle: o_Err pulse, code 10, go to IDLE.
  - DV arriving in the same cycle the count would expire: DV wins, the byte is processed and the counter clears.
  - The counter is held at 0 in IDLE and HOLD.
- i_Frame_Ack outside HOLD is ignored.
- o_Err never asserts in two consecutive cycles for one event. Back-to-back events each produce their own pulse.
- Stray bytes in IDLE are ignored; a SYNC value appearing inside a frame is treated as data.

Test Plan:
- Good frame: bytes A5 01 03 10 20 30 02 -> writes (addr 0,10), (1,20), (2,30), each as a one-cycle o_Wr_En. Then o_Frame_Valid=1, Cmd=01, Len=03, held until ack. Ack drops valid the next cycle.
- Zero-length frame: A5 07 00 07 -> no o_Wr_En; o_Frame_Valid=1, Cmd=07, Len=00.
- Bad checksum: A5 01 03 10 20 30 FF -> three writes, then o_Err=1 for one cycle with code 01. o_Frame_Valid stays 0. A following good frame is accepted.
- Timeout with TIMEOUT_CLKS=100: A5 01, then silence -> o_Err code 10 exactly 100 clocks after the 01 strobe; state returns to IDLE. Separate case: DV on the expiry cycle is accepted with no error.
- Overrun: good frame left unacked, then A5 arrives -> o_Err code 11; o_Frame_Valid and Cmd/Len unchanged. After ack, a new frame is accepted.
- Reset mid-payload: assert i_Reset after the 2nd payload byte -> all outputs 0 the next cycle. A subsequent complete frame parses correctly from index 0.
